// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
`default_nettype none

package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/muldiv_signfix.sv
// Combinational conditional two's-complement negate.
`default_nettype none

module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  assign val_o = neg_i ? ((~val_i) + WIDTH'(1)) : val_i;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO; signed variants exist only
// when MULDIV_SIGNED_EN is defined.
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   rs_mag, rt_mag, quo_res, rem_res;
  logic [2*WIDTH-1:0] prod_res;

`ifdef MULDIV_SIGNED_EN
  logic neg_res_q, neg_rem_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      neg_res_q <= op[0] & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
      neg_rem_q <= op[0] & rs_data[WIDTH-1];
    end
  end

  muldiv_signfix #(.WIDTH(WIDTH)) u_rs_mag (
    .val_i(rs_data), .neg_i(op[0] & rs_data[WIDTH-1]), .val_o(rs_mag));
  muldiv_signfix #(.WIDTH(WIDTH)) u_rt_mag (
    .val_i(rt_data), .neg_i(op[0] & rt_data[WIDTH-1]), .val_o(rt_mag));
  muldiv_signfix #(.WIDTH(2*WIDTH)) u_prod_fix (
    .val_i(acc_q), .neg_i(neg_res_q), .val_o(prod_res));
  muldiv_signfix #(.WIDTH(WIDTH)) u_quo_fix (
    .val_i(acc_q[WIDTH-1:0]), .neg_i(neg_res_q), .val_o(quo_res));
  muldiv_signfix #(.WIDTH(WIDTH)) u_rem_fix (
    .val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(neg_rem_q), .val_o(rem_res));
`else
  logic unused_op0;
  assign unused_op0 = op[0];
  assign rs_mag     = rs_data;
  assign rt_mag     = rt_data;
  assign prod_res   = acc_q;
  assign quo_res    = acc_q[WIDTH-1:0];
  assign rem_res    = acc_q[2*WIDTH-1:WIDTH];
`endif

  // Multiply: accumulator holds {partial product, remaining multiplier bits}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: accumulator holds {partial remainder, dividend/quotient bits}.
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic [2*WIDTH-1:0] div_step;
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, opnd_q};
  assign div_step = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = done_q;
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d = op[1];
          div0_d   = (rt_data == '0);
          opnd_d   = op[1] ? rt_mag : rs_mag;
          acc_d    = op[1] ? {{WIDTH{1'b0}}, rs_mag} : {{WIDTH{1'b0}}, rt_mag};
          cnt_d    = '0;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        acc_d = is_div_q ? div_step : mul_step;
      end
      S_FIX: begin
        done_d = 1'b1;
        if (is_div_q) begin
          lo_d = div0_q ? '1 : quo_res;
          hi_d = rem_res;
        end else begin
          {hi_d, lo_d} = prod_res;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic reference model.
`default_nettype none

module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] rs_data, rt_data, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Returns {HI, LO} as the architecture defines them.
  function automatic logic [63:0] ref_model(input logic [1:0] f_op,
                                            input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    logic signed [63:0] sp;
    int sa, sb;
`ifdef MULDIV_SIGNED_EN
    sgn = f_op[0];
`else
    sgn = 1'b0;
`endif
    if (!f_op[1]) begin
      if (sgn) begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      return {32'd0, a} * {32'd0, b};
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa = a;
      sb = b;
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b);
    op      = f_op;
    rs_data = a;
    rt_data = b;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    rs_data = $urandom;
    rt_data = $urandom;
    op      = 2'($urandom);
  endtask

  task automatic wait_done(output int n, output logic bad_done, output logic moved);
    logic [31:0] h0, l0;
    h0 = hi;
    l0 = lo;
    n = 0;
    bad_done = 1'b0;
    moved = 1'b0;
    while (busy && n < 40) begin
      n++;
      if (done) bad_done = 1'b1;
      if (hi !== h0 || lo !== l0) moved = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] f_op,
                        input logic [31:0] a, input logic [31:0] b);
    int n;
    logic bd, mv;
    logic [63:0] exp;
    exp = ref_model(f_op, a, b);
    launch(f_op, a, b);
    wait_done(n, bd, mv);
    chk({tag, "/busy_cycles"}, 64'(n), 64'd33);
    chk({tag, "/done"}, {63'd0, done}, 64'd1);
    chk({tag, "/done_while_busy"}, {63'd0, bd}, 64'd0);
    chk({tag, "/hilo_moved_in_run"}, {63'd0, mv}, 64'd0);
    chk({tag, "/hilo"}, {hi, lo}, exp);
  endtask

  initial begin
    int n;
    logic bd, mv;
    logic [1:0] rop;
    logic [31:0] ra, rb;

    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; rs_data = '0; rt_data = '0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst/busy", {63'd0, busy}, 64'd0);
    chk("rst/done", {63'd0, done}, 64'd0);
    chk("rst/hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed operations, each started in the previous done cycle.
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max/const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7);
    chk("divu_100_7/const", {hi, lo}, {32'd2, 32'd14});
    run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_by0", OP_DIVU, 32'h1234, 32'd0);
    chk("divu_by0/const", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});
    run_op("div_by0_neg", OP_DIV, 32'hFFFF_F000, 32'd0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), rop, ra, rb);
    end
    @(negedge clk);
    chk("done_single_pulse", {63'd0, done}, 64'd0);

    // start/MTHI during RUN are ignored.
    launch(OP_MULTU, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    op = OP_DIVU; rs_data = $urandom; rt_data = $urandom;
    start = 1'b1; hi_we = 1'b1; wdata = 32'hAA;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    wait_done(n, bd, mv);
    chk("busy_ign/remaining_cycles", 64'(n), 64'd23);
    chk("busy_ign/done", {63'd0, done}, 64'd1);
    chk("busy_ign/hilo", {hi, lo}, {32'd0, 32'd30});
    @(negedge clk);

    // MTHI / MTLO in IDLE.
    hi_we = 1'b1; wdata = 32'h1357_9BDF;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", {hi, lo}, {32'h1357_9BDF, 32'd30});
    lo_we = 1'b1; wdata = 32'h2468_ACE0;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo", {hi, lo}, {32'h1357_9BDF, 32'h2468_ACE0});
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0F0F_F0F0;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi_mtlo", {hi, lo}, {32'h0F0F_F0F0, 32'h0F0F_F0F0});

    // start wins over a same-cycle MTHI.
    op = OP_MULTU; rs_data = 32'd2; rt_data = 32'd3;
    start = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    chk("start_prio/busy", {63'd0, busy}, 64'd1);
    chk("start_prio/hi_held", {32'd0, hi}, {32'd0, 32'h0F0F_F0F0});
    wait_done(n, bd, mv);
    chk("start_prio/hilo", {hi, lo}, {32'd0, 32'd6});

    // Reset in the middle of an operation.
    hi_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    hi_we = 1'b0;
    launch(OP_DIVU, 32'd1000, 32'd3);
    repeat (14) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort/busy", {63'd0, busy}, 64'd0);
    chk("abort/hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bd = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) bd = 1'b1;
    end
    chk("abort/no_done", {63'd0, bd}, 64'd0);
    run_op("after_abort", OP_DIVU, 32'd1000, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
